// File: rtl/klotski_pkg.sv
// Shared board geometry, scheduler state encoding and move legality
// for the Klotski move-overlay path.
package klotski_pkg;

    localparam int BOARD_DIM = 4;
    localparam int CELL_W    = 4;
    localparam int MOVE_W    = 2 * CELL_W;
    localparam int COL_W     = $clog2(BOARD_DIM);

    typedef logic [CELL_W-1:0] cell_t;
    typedef logic [CELL_W:0]   cell_wide_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_SHOW,
        ST_CLEAR
    } sched_state_e;

    // One orthogonal step; the extra bit keeps +/-BOARD_DIM from wrapping around the board.
    function automatic logic is_legal_move(input cell_t from, input cell_t to);
        cell_wide_t f;
        cell_wide_t t;
        logic       same_row;
        f        = {1'b0, from};
        t        = {1'b0, to};
        same_row = (from[CELL_W-1:COL_W] == to[CELL_W-1:COL_W]);
        return (same_row && (t == f + cell_wide_t'(1)))
            || (same_row && (f == t + cell_wide_t'(1)))
            || (t == f + cell_wide_t'(BOARD_DIM))
            || (f == t + cell_wide_t'(BOARD_DIM));
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Small FIFO of pending {from,to} moves; wrap-bit pointers distinguish full from empty.
module move_fifo
    import klotski_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [MOVE_W-1:0] wdata,
    input  logic              pop,
    output logic [MOVE_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [MOVE_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && !full) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop && !empty) rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // NOTE: storage is not reset; only the pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/move_overlay_sched.sv
// Arbitrates solver/user move requests, queues legal ones and paces them onto the
// VGA overlay one per HOLD_FRAMES frames, blanking the highlight when the queue drains.
module move_overlay_sched
    import klotski_pkg::*;
#(
    parameter int HOLD_FRAMES = 30,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iV_SYNC,
    input  logic [1:0]        iReq_valid,
    input  logic [CELL_W-1:0] iReq_from0,
    input  logic [CELL_W-1:0] iReq_to0,
    input  logic [CELL_W-1:0] iReq_from1,
    input  logic [CELL_W-1:0] iReq_to1,
    output logic [1:0]        oReq_ready,
    input  logic              iFlush,
    output logic [CELL_W-1:0] oFromBlock,
    output logic [CELL_W-1:0] oToBlock,
    output logic              oBM_EN,
    output logic              oErr,
    output logic              oBusy
);
    localparam int              CNT_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_FRAMES - 1);

    sched_state_e      state_q, state_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CELL_W-1:0] from_q, from_d, to_q, to_d;
    logic              bm_en_q, bm_en_d;
    logic              err_q, err_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              flush_pend_q, flush_pend_d;
    logic              vs_q, run_q;

    logic              grant, accept, vs_rise, do_load, do_clear;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [MOVE_W-1:0] req_move, head_move;

    assign vs_rise = iV_SYNC && !vs_q;

    always_comb begin
        grant = rr_ptr_q;
        if (iReq_valid == 2'b01)      grant = 1'b0;
        else if (iReq_valid == 2'b10) grant = 1'b1;
    end

    // run_q keeps ready low while reset is held, even with requesters valid.
    always_comb begin
        oReq_ready = 2'b00;
        if (run_q && !fifo_full && !iFlush && iReq_valid[grant]) oReq_ready[grant] = 1'b1;
    end

    assign accept    = |(oReq_ready & iReq_valid);
    assign req_move  = grant ? {iReq_from1, iReq_to1} : {iReq_from0, iReq_to0};
    assign fifo_push = accept && is_legal_move(req_move[MOVE_W-1:CELL_W], req_move[CELL_W-1:0]);
    assign err_d     = accept && !fifo_push;
    assign rr_ptr_d  = (accept && (&iReq_valid)) ? !rr_ptr_q : rr_ptr_q;

    move_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .flush (iFlush),
        .push  (fifo_push),
        .wdata (req_move),
        .pop   (fifo_pop),
        .rdata (head_move),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        from_d       = from_q;
        to_d         = to_q;
        bm_en_d      = 1'b0;
        fifo_pop     = 1'b0;
        flush_pend_d = flush_pend_q;
        do_load      = 1'b0;
        do_clear     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                flush_pend_d = 1'b0;
                if (!fifo_empty && !iFlush) state_d = ST_WAIT_VS;
            end
            ST_WAIT_VS: begin
                if (iFlush)       state_d = ST_IDLE;
                else if (vs_rise) do_load = 1'b1;
            end
            ST_SHOW: begin
                if (iFlush) flush_pend_d = 1'b1;
                if (vs_rise) begin
                    if (iFlush || flush_pend_q)  do_clear = 1'b1;
                    else if (frame_cnt_q != '0)  frame_cnt_d = frame_cnt_q - CNT_W'(1);
                    else if (!fifo_empty)        do_load = 1'b1;
                    else                         do_clear = 1'b1;
                end
            end
            ST_CLEAR: state_d = ST_IDLE;
        endcase

        if (do_load) begin
            fifo_pop    = 1'b1;
            from_d      = head_move[MOVE_W-1:CELL_W];
            to_d        = head_move[CELL_W-1:0];
            bm_en_d     = 1'b1;
            frame_cnt_d = CNT_LOAD;
            state_d     = ST_SHOW;
        end
        // Equal from/to makes the VGA controller draw nothing, which blanks the highlight.
        if (do_clear) begin
            from_d       = '0;
            to_d         = '0;
            bm_en_d      = 1'b1;
            frame_cnt_d  = '0;
            flush_pend_d = 1'b0;
            state_d      = ST_CLEAR;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= '0;
            from_q       <= '0;
            to_q         <= '0;
            bm_en_q      <= 1'b0;
            err_q        <= 1'b0;
            rr_ptr_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            vs_q         <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            from_q       <= from_d;
            to_q         <= to_d;
            bm_en_q      <= bm_en_d;
            err_q        <= err_d;
            rr_ptr_q     <= rr_ptr_d;
            flush_pend_q <= flush_pend_d;
            vs_q         <= iV_SYNC;
            run_q        <= 1'b1;
        end
    end

    assign oFromBlock = from_q;
    assign oToBlock   = to_q;
    assign oBM_EN     = bm_en_q;
    assign oErr       = err_q;
    assign oBusy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule
